apb_master_bridge: RTL and testbench

//   APB requester (master) that drives the APB register files from a simple command/response

---
 rtl/apb_master_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// APB requester that turns one command from a valid/ready command channel
// into exactly one APB SETUP + ACCESS transfer. It then returns the read data
// and the slave error flag on a valid/ready response channel. Only one
// transfer is in flight at a time, and every output is driven from a flop.
//
// Optional build feature:
//   APB_MASTER_TIMEOUT_EN  When defined, an ACCESS phase that waits
//                          TIMEOUT_CYCLES cycles without pready is abandoned.
//                          It completes with rsp_err=1 and rsp_rdata=0.
//                          When undefined, ACCESS waits for pready
//                          indefinitely and TIMEOUT_CYCLES is unused.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write/cmd_addr/cmd_wdata  command payload (wdata ignored for reads)
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_err             read data (0 for writes) / slave error or timeout
//   paddr/psel/penable/pwrite/pwdata   APB request signals
//   prdata/pready/pslverr              APB completion signals
// ---------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Next values for the registered outputs.
    logic              cmd_ready_nxt;
    logic              rsp_valid_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;
    logic              rsp_err_nxt;
    logic [ADDR_W-1:0] paddr_nxt;
    logic              psel_nxt;
    logic              penable_nxt;
    logic              pwrite_nxt;
    logic [DATA_W-1:0] pwdata_nxt;

    logic cmd_fire;
    logic access_done;
    logic timeout_hit;

    // cmd_ready is high only in IDLE, so the handshake alone marks acceptance.
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign access_done = (state == ACCESS) && pready;

`ifdef APB_MASTER_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // The limit fires on the edge where the count would reach TIMEOUT_CYCLES.
    // A pready arriving on that same edge takes priority as a normal completion.
    assign timeout_hit = (state == ACCESS) && !pready
                         && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !pready) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // -------------------------------------------------------------------
    // State register and registered outputs
    // -------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            paddr     <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
            paddr     <= paddr_nxt;
            psel      <= psel_nxt;
            penable   <= penable_nxt;
            pwrite    <= pwrite_nxt;
            pwdata    <= pwdata_nxt;
        end
    end

    // -------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------
    // NOTE: each combinational block assigns every target a default first,
    // so that no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (cmd_fire)                   state_nxt = SETUP;
            SETUP:                                  state_nxt = ACCESS;
            ACCESS: if (access_done || timeout_hit) state_nxt = RESP;
            RESP:   if (rsp_ready)                  state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------
    // Output logic: next values of the output flops
    // -------------------------------------------------------------------
    always_comb begin
        cmd_ready_nxt = cmd_ready;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        paddr_nxt     = paddr;
        psel_nxt      = psel;
        penable_nxt   = penable;
        pwrite_nxt    = pwrite;
        pwdata_nxt    = pwdata;

        unique case (state)
            IDLE: begin
                if (cmd_fire) begin
                    paddr_nxt     = cmd_addr;
                    pwrite_nxt    = cmd_write;
                    pwdata_nxt    = cmd_wdata;
                    cmd_ready_nxt = 1'b0;
                    psel_nxt      = 1'b1;
                    penable_nxt   = 1'b0;
                end
            end
            SETUP: begin
                // pready and pslverr are deliberately ignored during SETUP.
                penable_nxt = 1'b1;
            end
            ACCESS: begin
                if (access_done) begin
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = pwrite ? '0 : prdata;
                    rsp_err_nxt   = pslverr;
                end else if (timeout_hit) begin
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                end
            end
            RESP: begin
                // The response stays held until the consumer takes it.
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                end
            end
            default: begin
                cmd_ready_nxt = 1'b1;
                psel_nxt      = 1'b0;
                penable_nxt   = 1'b0;
                rsp_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Directed, self-checking bench for apb_master_bridge.
// Inputs change, and outputs are sampled, 1 ns after each rising edge.
// When APB_MASTER_TIMEOUT_EN is defined, the DUT is built with
// TIMEOUT_CYCLES=4 and the stuck-pready scenario is also exercised.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TO_CYCLES = 4;
`else
    localparam int TO_CYCLES = 255;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    int errors = 0;
    int checks = 0;

    apb_master_bridge #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    int setups;
    int rsps;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b1;
        pslverr   = 1'b0;
        tick();
        tick();

        // ---------------- reset state ----------------
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_psel",      32'(psel),      32'd0);
        check("rst_penable",   32'(penable),   32'd0);
        check("rst_pwrite",    32'(pwrite),    32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_paddr",     32'(paddr),     32'd0);
        check("rst_pwdata",    pwdata,         32'd0);
        check("rst_rsp_rdata", rsp_rdata,      32'd0);
        rst = 1'b0;
        tick();

        // ---------------- 1: write, pready high ----------------
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h04;
        cmd_wdata = 32'hDEADBEEF;
        tick();  // edge N: accept
        cmd_valid = 1'b0;
        check("t1_setup_psel",      32'(psel),      32'd1);
        check("t1_setup_penable",   32'(penable),   32'd0);
        check("t1_setup_cmd_ready", 32'(cmd_ready), 32'd0);
        check("t1_setup_paddr",     32'(paddr),     32'h04);
        check("t1_setup_pwrite",    32'(pwrite),    32'd1);
        check("t1_setup_pwdata",    pwdata,         32'hDEADBEEF);
        check("t1_setup_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();  // N+1 -> ACCESS
        check("t1_acc_psel",      32'(psel),      32'd1);
        check("t1_acc_penable",   32'(penable),   32'd1);
        check("t1_acc_paddr",     32'(paddr),     32'h04);
        check("t1_acc_pwdata",    pwdata,         32'hDEADBEEF);
        check("t1_acc_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();  // N+2 -> RESP
        check("t1_rsp_valid",   32'(rsp_valid), 32'd1);
        check("t1_rsp_rdata",   rsp_rdata,      32'd0);
        check("t1_rsp_err",     32'(rsp_err),   32'd0);
        check("t1_rsp_psel",    32'(psel),      32'd0);
        check("t1_rsp_penable", 32'(penable),   32'd0);
        rsp_ready = 1'b1;
        tick();  // N+3 handshake
        rsp_ready = 1'b0;
        check("t1_done_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t1_done_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t1_idle_paddr",     32'(paddr),     32'h04);

        // ---------------- 2: read with 3 wait states ----------------
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h08;
        cmd_wdata = 32'h0BADF00D;
        pready    = 1'b0;
        tick();  // accept
        cmd_valid = 1'b0;
        check("t2_setup_psel", 32'(psel), 32'd1);
        tick();  // ACCESS cycle 1
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_acc%0d_psel", i),    32'(psel),      32'd1);
            check($sformatf("t2_acc%0d_penable", i), 32'(penable),   32'd1);
            check($sformatf("t2_acc%0d_paddr", i),   32'(paddr),     32'h08);
            check($sformatf("t2_acc%0d_pwrite", i),  32'(pwrite),    32'd0);
            check($sformatf("t2_acc%0d_rvalid", i),  32'(rsp_valid), 32'd0);
            if (i == 3) begin
                pready = 1'b1;
                prdata = 32'h12345678;
            end
            tick();
        end
        prdata = 32'hFFFF0000;
        check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t2_rsp_rdata", rsp_rdata,      32'h12345678);
        check("t2_rsp_err",   32'(rsp_err),   32'd0);
        check("t2_rsp_psel",  32'(psel),      32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t2_done_cmd_ready", 32'(cmd_ready), 32'd1);

        // ---------------- 3: read with pslverr, held response ----------------
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h0C;
        pready    = 1'b1;
        tick();  // accept
        cmd_valid = 1'b0;
        pslverr   = 1'b1;  // ignored in SETUP; sampled at completion
        prdata    = 32'hA5A5A5A5;
        tick();  // ACCESS
        tick();  // RESP
        pslverr = 1'b0;
        prdata  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_hold%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("t3_hold%0d_rsp_rdata", i), rsp_rdata,      32'hA5A5A5A5);
            check($sformatf("t3_hold%0d_rsp_err", i),   32'(rsp_err),   32'd1);
            check($sformatf("t3_hold%0d_cmd_ready", i), 32'(cmd_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("t3_done_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t3_done_cmd_ready", 32'(cmd_ready), 32'd1);

        // rsp_ready with no response pending must change nothing
        tick();
        check("idle_rsp_ready_valid", 32'(rsp_valid), 32'd0);
        check("idle_rsp_ready_cmdrdy", 32'(cmd_ready), 32'd1);

        // ---------------- 4: back-to-back commands ----------------
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h10;
        cmd_wdata = 32'h11110000;
        setups    = 0;
        rsps      = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("t4_c%0d_cmd_ready", k), 32'(cmd_ready),
                  32'((k % 4) == 0));
            check($sformatf("t4_c%0d_rsp_valid", k), 32'(rsp_valid),
                  32'((k % 4) == 3));
            if (psel && !penable) setups++;
            if (rsp_valid) rsps++;
        end
        cmd_valid = 1'b0;
        check("t4_setup_count", 32'(setups), 32'd3);
        check("t4_rsp_count",   32'(rsps),   32'd3);
        rsp_ready = 1'b0;
        tick();
        check("t4_end_cmd_ready", 32'(cmd_ready), 32'd1);

        // ---------------- 5: reset during ACCESS ----------------
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h20;
        pready    = 1'b0;
        tick();  // SETUP
        cmd_valid = 1'b0;
        tick();  // ACCESS
        check("t5_acc_penable", 32'(penable), 32'd1);
        rst = 1'b1;
        tick();
        check("t5_rst_psel",      32'(psel),      32'd0);
        check("t5_rst_penable",   32'(penable),   32'd0);
        check("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t5_rst_paddr",     32'(paddr),     32'd0);
        rst       = 1'b0;
        pready    = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t5_after%0d_rsp_valid", i), 32'(rsp_valid), 32'd0);
            check($sformatf("t5_after%0d_psel", i),      32'(psel),      32'd0);
        end
        rsp_ready = 1'b0;

`ifdef APB_MASTER_TIMEOUT_EN
        // ---------------- 6: timeout with pready stuck low ----------------
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h30;
        pready    = 1'b0;
        prdata    = 32'hCAFEBABE;
        tick();  // SETUP
        cmd_valid = 1'b0;
        tick();  // ACCESS cycle 1
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("t6_acc%0d_psel", i), 32'(psel), 32'd1);
        end
        tick();
        check("t6_to_psel",      32'(psel),      32'd0);
        check("t6_to_penable",   32'(penable),   32'd0);
        check("t6_to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t6_to_rsp_err",   32'(rsp_err),   32'd1);
        check("t6_to_rsp_rdata", rsp_rdata,      32'd0);
        rsp_ready = 1'b1;
        pready    = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t6_done_cmd_ready", 32'(cmd_ready), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
